// File: rtl/event_blinker.sv
// event_blinker
//   Turns single-cycle event strobes into visible LED blinks. Each accepted
//   event produces one blink of ON_CYCLES lit cycles followed by at least
//   OFF_CYCLES dark cycles. Events that arrive while a blink is running are
//   remembered and replayed back to back, so blinks never merge or shorten.
//
// Build option:
//   EVENT_BLINKER_QUEUE_EN  defined   -> saturating pending counter
//                                        (0..PENDING_MAX). Events that arrive
//                                        while it is full are dropped, and
//                                        overflow pulses for one cycle.
//   EVENT_BLINKER_QUEUE_EN  undefined -> 1-bit pending flag. Extra events
//                                        merge silently, and overflow is 0.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   event_in   in   synchronous event strobe (one event per high cycle)
//   led_out    out  registered LED drive, high = lit
//   busy       out  registered, high whenever the FSM is not idle
//   overflow   out  registered one-cycle strobe: an event was dropped
//   state_dbg  out  current FSM state (0 idle, 1 on, 2 gap)
module event_blinker #(
  parameter int ON_CYCLES   = 4,
  parameter int OFF_CYCLES  = 2,
  parameter int PENDING_MAX = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       event_in,
  output logic       led_out,
  output logic       busy,
  output logic       overflow,
  output logic [1:0] state_dbg
);

  // The dwell counter counts down from (phase length - 1) to 0, so it only
  // ever has to hold values below the longer of the two phases.
  localparam int DWELL_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CNT_W     = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t           state = ST_IDLE;
  state_t           state_next;
  logic [CNT_W-1:0] dwell = '0;
  logic [CNT_W-1:0] dwell_next;
  logic             pend_inc;
  logic             pend_dec;
  logic             pend_nonzero;
  logic             drop;

  assign state_dbg = state;

  // ------------------------------------------------------------------
  // Pending-event store
  // ------------------------------------------------------------------
`ifdef EVENT_BLINKER_QUEUE_EN
  localparam int PEND_W = $clog2(PENDING_MAX + 1);

  logic [PEND_W-1:0] pending = '0;

  assign pend_nonzero = (pending != '0);
  // When a replay is consumed in the same cycle, a slot frees up, so an
  // event arriving then is kept even if the counter currently reads full.
  assign drop = pend_inc && !pend_dec && (pending == PEND_W'(PENDING_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else if (pend_inc && !pend_dec && !drop) begin
      pending <= pending + PEND_W'(1);
    end else if (pend_dec && !pend_inc) begin
      pending <= pending - PEND_W'(1);
    end
  end
`else
  logic pending = 1'b0;
  logic unused_pending_max;

  assign unused_pending_max = (PENDING_MAX > 0);
  assign pend_nonzero = pending;
  assign drop         = 1'b0;

  // A set flag absorbs further events; inc and dec together keep it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (pend_inc && !pend_dec) begin
      pending <= 1'b1;
    end else if (pend_dec && !pend_inc) begin
      pending <= 1'b0;
    end
  end
`endif

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      dwell <= '0;
    end else begin
      state <= state_next;
      dwell <= dwell_next;
    end
  end

  always_comb begin
    state_next = state;
    dwell_next = dwell;
    pend_inc   = 1'b0;
    pend_dec   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (event_in) begin
          state_next = ST_ON;
          dwell_next = ON_LOAD;
        end
      end
      ST_ON: begin
        pend_inc = event_in;
        if (dwell == '0) begin
          state_next = ST_GAP;
          dwell_next = OFF_LOAD;
        end else begin
          dwell_next = dwell - CNT_W'(1);
        end
      end
      ST_GAP: begin
        pend_inc = event_in;
        if (dwell == '0) begin
          if (pend_nonzero) begin
            state_next = ST_ON;
            dwell_next = ON_LOAD;
            pend_dec   = 1'b1;
          end else if (event_in) begin
            // An event in the last gap cycle starts the next blink directly
            // instead of passing through the pending store.
            state_next = ST_ON;
            dwell_next = ON_LOAD;
            pend_inc   = 1'b0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          dwell_next = dwell - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        dwell_next = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state register.
  logic led_q      = 1'b0;
  logic busy_q     = 1'b0;
  logic overflow_q = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q      <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      led_q      <= (state_next == ST_ON);
      busy_q     <= (state_next != ST_IDLE);
      overflow_q <= drop;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_event_blinker.sv
// tb_event_blinker
//   Bench for event_blinker with ON_CYCLES=4, OFF_CYCLES=2, PENDING_MAX=3.
//   Directed scenarios live in a vector table (inputs of cycle t, outputs
//   expected in cycle t+1); a random phase compares against a timeline model
//   that tracks blink start times and a pending count.
module tb_event_blinker;

  localparam int ON  = 4;
  localparam int OFF = 2;
  localparam int PM  = 3;
`ifdef EVENT_BLINKER_QUEUE_EN
  localparam int CAP    = PM;
  localparam bit Q_OVF  = 1'b1;
`else
  localparam int CAP    = 1;
  localparam bit Q_OVF  = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       event_in = 1'b0;
  logic       led_out;
  logic       busy;
  logic       overflow;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  event_blinker #(
    .ON_CYCLES  (ON),
    .OFF_CYCLES (OFF),
    .PENDING_MAX(PM)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .event_in (event_in),
    .led_out  (led_out),
    .busy     (busy),
    .overflow (overflow),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  // Inputs are applied 1 time unit after an edge; outputs are read 1 time
  // unit after the following edge.
  task automatic drive_cycle(input logic rst, input logic ev);
    reset    = rst;
    event_in = ev;
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst;
    logic ev;
    logic led;
    logic busy;
    logic ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] win(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic add_scenario(input int len, input logic [63:0] rst_b,
                              input logic [63:0] ev_b, input logic [63:0] led_b,
                              input logic [63:0] busy_b, input logic [63:0] ovf_b);
    for (int t = 0; t < len; t++) begin
      vec_t v;
      v.rst  = rst_b[t];
      v.ev   = ev_b[t];
      v.led  = led_b[t+1];
      v.busy = busy_b[t+1];
      v.ovf  = ovf_b[t+1];
      vecs.push_back(v);
    end
  endtask

  // ---------------- reference model ----------------
  // A blink is a window of ON lit cycles plus OFF dark cycles starting at
  // m_start. m_active means the cycle being predicted lies in such a window.
  int m_t;
  int m_start;
  int m_pend;
  bit m_active;

  task automatic model_step(input bit ev, input bit rst,
                            output bit e_led, output bit e_busy, output bit e_ovf);
    int c1;
    int end_c;
    bit at_end;
    c1    = m_t + 1;
    e_ovf = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_pend   = 0;
    end else if (!m_active) begin
      if (ev) begin
        m_active = 1'b1;
        m_start  = c1;
      end
    end else begin
      end_c  = m_start + ON + OFF;
      at_end = (c1 == end_c);
      if (ev) begin
        if (m_pend < CAP || at_end) m_pend++;
        else e_ovf = Q_OVF;
      end
      if (at_end) begin
        if (m_pend > 0) begin
          m_pend--;
          m_start = c1;
        end else begin
          m_active = 1'b0;
        end
      end
    end
    m_t++;
    e_busy = m_active;
    e_led  = m_active && ((c1 - m_start) < ON);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] rst2;
    bit e_led, e_busy, e_ovf, rst_r, ev_r;
    int probs[4];

    rst2 = win(0, 1);

    // Single event.
    add_scenario(22, rst2, win(10, 10), win(11, 14), win(11, 16), '0);
    // Event in the last gap cycle chains with no idle cycle.
    add_scenario(26, rst2, win(10, 10) | win(16, 16),
                 win(11, 14) | win(17, 20), win(11, 22), '0);
    // Reset mid-blink, with an event in the reset cycle.
    add_scenario(26, rst2 | win(12, 12), win(10, 10) | win(12, 12),
                 win(11, 12), win(11, 12), '0);
`ifdef EVENT_BLINKER_QUEUE_EN
    // Three queued events replay back to back.
    add_scenario(38, rst2, win(10, 10) | win(12, 14),
                 win(11, 14) | win(17, 20) | win(23, 26) | win(29, 32),
                 win(11, 34), '0);
    // Fifth event overflows the three-deep queue.
    add_scenario(38, rst2, win(10, 14),
                 win(11, 14) | win(17, 20) | win(23, 26) | win(29, 32),
                 win(11, 34), win(15, 15));
`else
    // Extra events merge into the single pending flag.
    add_scenario(28, rst2, win(10, 10) | win(12, 13),
                 win(11, 14) | win(17, 20), win(11, 22), '0);
`endif

    // Power-up values before any clock edge.
    #1;
    check("powerup led_out", led_out, 1'b0);
    check("powerup busy", busy, 1'b0);
    check("powerup overflow", overflow, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_cycle(vecs[i].rst, vecs[i].ev);
      check($sformatf("vec%0d led_out", i), led_out, vecs[i].led);
      check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d overflow", i), overflow, vecs[i].ovf);
    end

    // Random phase against the timeline model.
    m_t      = 0;
    m_start  = 0;
    m_pend   = 0;
    m_active = 1'b0;
    probs[0] = 5;
    probs[1] = 20;
    probs[2] = 50;
    probs[3] = 90;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 600; k++) begin
        rst_r = ((b == 0) && (k == 0)) || ($urandom_range(0, 149) == 0);
        ev_r  = ($urandom_range(0, 99) < probs[b]);
        model_step(ev_r, rst_r, e_led, e_busy, e_ovf);
        drive_cycle(rst_r, ev_r);
        check($sformatf("rnd%0d_%0d led_out", b, k), led_out, e_led);
        check($sformatf("rnd%0d_%0d busy", b, k), busy, e_busy);
        check($sformatf("rnd%0d_%0d overflow", b, k), overflow, e_ovf);
      end
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/event_blinker.md
EVENT_BLINKER -- requirements
Module: event_blinker

Interface
REQ-001 Parameter ON_CYCLES, default 4: led_out high time per blink, in clk cycles; legal range >= 1.
REQ-002 Parameter OFF_CYCLES, default 2: minimum led_out low gap after every blink, in clk cycles; legal range >= 1.
REQ-003 Parameter PENDING_MAX, default 3: queued-event capacity, used only when the queue is compiled in; legal range >= 1.
REQ-004 Port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port reset  input  1  reset, synchronous and active-high.
REQ-006 Port event_in  input  1  already-synchronous event strobe; each high cycle is one event.
REQ-007 Port led_out  output  1  registered LED drive; high = lit.
REQ-008 Port busy  output  1  registered; high whenever the state is not IDLE.
REQ-009 Port overflow  output  1  registered one-cycle strobe: an event was dropped.

Function
REQ-010 The state machine SHALL have three states: IDLE, ON and GAP.
REQ-011 State IDLE SHALL hold led_out=0 and busy=0.
REQ-012 An event sampled in IDLE at edge N SHALL move the state to ON, with led_out=1 from edge N+1.
REQ-013 State ON SHALL last exactly ON_CYCLES cycles with led_out=1, then move to GAP.
REQ-014 State GAP SHALL last exactly OFF_CYCLES cycles with led_out=0.
REQ-015 At the end of GAP, pending>0 SHALL start the next ON in the following cycle and decrement pending; otherwise the state SHALL move to IDLE.
REQ-016 An event sampled in ON or GAP SHALL increment pending; this includes the last GAP cycle, in which case the event starts the next ON with no idle cycle.
REQ-017 An increment and a decrement in the same cycle SHALL leave pending unchanged.
REQ-018 An event arriving while pending is full SHALL be dropped, and overflow SHALL be 1 for exactly the next cycle.
REQ-019 The dwell counter SHALL be sized for max(ON_CYCLES, OFF_CYCLES) and SHALL never wrap.
REQ-020 Each accepted event SHALL produce exactly one blink; blinks SHALL never merge or shorten.

Reset
REQ-021 While reset=1 at an edge, the next state SHALL be IDLE with pending=0, led_out=0, busy=0 and overflow=0.
REQ-022 event_in in a reset cycle SHALL be ignored.
REQ-023 Reset asserted mid-ON or mid-GAP SHALL abort immediately: no residual blink and no queued blink after release.
REQ-024 Power-up initial values SHALL equal the reset values.

Configuration
REQ-025 Macro EVENT_BLINKER_QUEUE_EN defined: pending SHALL be a saturating counter from 0 to PENDING_MAX, and overflow SHALL behave as in REQ-018.
REQ-026 Macro EVENT_BLINKER_QUEUE_EN undefined: pending SHALL be a 1-bit flag and PENDING_MAX SHALL be ignored.
REQ-027 Macro EVENT_BLINKER_QUEUE_EN undefined: extra events while the flag is set SHALL merge silently, and overflow SHALL be constant 0.

Verification (ON=4, OFF=2, PENDING_MAX=3)
REQ-028 Single event at cycle 10 -> led_out=1 in cycles 11-14; busy=1 in cycles 11-16; busy=0 from cycle 17.
REQ-029 Queue on; events at 10, 12, 13, 14 -> led_out=1 in 11-14, 17-20, 23-26 and 29-32; overflow stays 0.
REQ-030 Queue on; events at 10, 11, 12, 13, 14 -> overflow=1 only in cycle 15; exactly four blinks.
REQ-031 Queue off; events at 10, 12, 13 -> blinks only in 11-14 and 17-20; overflow stays 0.
REQ-032 Event at 10, reset=1 in cycle 12 with event_in=1 -> led_out=0 and busy=0 from 13; no later blink.
REQ-033 Events at 10 and 16 (last GAP cycle) -> second blink in 17-20 with no idle cycle in between.
